// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback states and
// drives all datapath mux selects and enables, with memory handshake, bubbles and illegal trap.
module multicycle_control #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       Op_i,
   input  logic             NoOp_i,
   input  logic             MemReady_i,
   output logic             PCWrite_o,
   output logic             PCWriteCond_o,
   output logic             IorD_o,
   output logic             MemRd_o,
   output logic             MemWr_o,
   output logic             IRWrite_o,
   output logic             MemtoReg_o,
   output logic             RegWrite_o,
   output logic             RegDst_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       PCSrc_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic             Retire_o,
   output logic             Illegal_o,
   output logic [3:0]       State_o,
   output logic [CNT_W-1:0] InstrCnt_o
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StAddiEx = 4'd10,
      StAddiWb = 4'd11
   } state_e;

   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpJ    = 6'b000010;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             rdy;

   // With MEM_WAIT=0 memory is assumed single-cycle and the handshake is ignored.
   assign rdy        = MemReady_i | (MEM_WAIT == 0);
   assign State_o    = state_q;
   assign InstrCnt_o = cnt_q;

   always_comb begin
      state_d       = state_q;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRd_o       = 1'b0;
      MemWr_o       = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      RegWrite_o    = 1'b0;
      RegDst_o      = 1'b0;
      ALUSrcA_o     = 1'b0;
      PCSrc_o       = 2'b00;
      ALUSrcB_o     = 2'b00;
      ALUOp_o       = 2'b00;
      Retire_o      = 1'b0;
      Illegal_o     = 1'b0;
      // Reset holds every output low; the state register is cleared in the sequential block.
      if (!rst_i) begin
         case (state_q)
            StFetch: begin
               MemRd_o   = 1'b1;
               ALUSrcB_o = 2'b01;
               IRWrite_o = rdy;
               PCWrite_o = rdy;
               if (rdy) state_d = StDecode;
            end
            StDecode: begin
               ALUSrcB_o = 2'b11;
               if (NoOp_i) begin
                  state_d = StFetch;
               end else begin
                  case (Op_i)
                     OpLw, OpSw: state_d = StMemAdr;
                     OpR:        state_d = StExec;
                     OpBeq:      state_d = StBranch;
                     OpJ:        state_d = StJump;
                     OpAddi:     state_d = StAddiEx;
                     default: begin
                        state_d   = StFetch;
                        Illegal_o = 1'b1;
                     end
                  endcase
               end
            end
            StMemAdr: begin
               ALUSrcA_o = 1'b1;
               ALUSrcB_o = 2'b10;
               state_d   = (Op_i == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
               MemRd_o = 1'b1;
               IorD_o  = 1'b1;
               if (rdy) state_d = StMemWb;
            end
            StMemWb: begin
               RegWrite_o = 1'b1;
               MemtoReg_o = 1'b1;
               Retire_o   = 1'b1;
               state_d    = StFetch;
            end
            StMemWr: begin
               MemWr_o = 1'b1;
               IorD_o  = 1'b1;
               if (rdy) begin
                  Retire_o = 1'b1;
                  state_d  = StFetch;
               end
            end
            StExec: begin
               ALUSrcA_o = 1'b1;
               ALUOp_o   = 2'b10;
               state_d   = StAluWb;
            end
            StAluWb: begin
               RegWrite_o = 1'b1;
               RegDst_o   = 1'b1;
               Retire_o   = 1'b1;
               state_d    = StFetch;
            end
            StBranch: begin
               ALUSrcA_o     = 1'b1;
               ALUOp_o       = 2'b01;
               PCWriteCond_o = 1'b1;
               PCSrc_o       = 2'b01;
               Retire_o      = 1'b1;
               state_d       = StFetch;
            end
            StJump: begin
               PCWrite_o = 1'b1;
               PCSrc_o   = 2'b10;
               Retire_o  = 1'b1;
               state_d   = StFetch;
            end
            StAddiEx: begin
               ALUSrcA_o = 1'b1;
               ALUSrcB_o = 2'b10;
               state_d   = StAddiWb;
            end
            StAddiWb: begin
               RegWrite_o = 1'b1;
               Retire_o   = 1'b1;
               state_d    = StFetch;
            end
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StFetch;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (Retire_o) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction vectors with a retire/illegal scoreboard
// on the default instance and a wrap/no-stall check on a narrow, non-waiting instance.
module tb_multicycle_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance (CNT_W=16, MEM_WAIT=1)
   logic        rst, noop, mr;
   logic [5:0]  op;
   logic        pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rdst0, asa0, ret0, ill0;
   logic [1:0]  pcs0, asb0, aop0;
   logic [3:0]  st0;
   logic [15:0] cnt0;
   logic [15:0] ctl0;

   // Narrow instance (CNT_W=4, MEM_WAIT=0)
   logic        rst1, noop1, mr1;
   logic [5:0]  op1;
   logic        pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rdst1, asa1, ret1, ill1;
   logic [1:0]  pcs1, asb1, aop1;
   logic [3:0]  st1;
   logic [3:0]  cnt1;
   logic [15:0] ctl1;

   assign ctl0 = {pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rdst0, asa0, pcs0, asb0, aop0};
   assign ctl1 = {pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rdst1, asa1, pcs1, asb1, aop1};

   multicycle_control #(.CNT_W(16), .MEM_WAIT(1)) dut0 (
      .clk_i(clk), .rst_i(rst), .Op_i(op), .NoOp_i(noop), .MemReady_i(mr),
      .PCWrite_o(pcw0), .PCWriteCond_o(pcwc0), .IorD_o(iord0), .MemRd_o(mrd0), .MemWr_o(mwr0),
      .IRWrite_o(irw0), .MemtoReg_o(m2r0), .RegWrite_o(rw0), .RegDst_o(rdst0),
      .ALUSrcA_o(asa0), .PCSrc_o(pcs0), .ALUSrcB_o(asb0), .ALUOp_o(aop0),
      .Retire_o(ret0), .Illegal_o(ill0), .State_o(st0), .InstrCnt_o(cnt0)
   );

   multicycle_control #(.CNT_W(4), .MEM_WAIT(0)) dut1 (
      .clk_i(clk), .rst_i(rst1), .Op_i(op1), .NoOp_i(noop1), .MemReady_i(mr1),
      .PCWrite_o(pcw1), .PCWriteCond_o(pcwc1), .IorD_o(iord1), .MemRd_o(mrd1), .MemWr_o(mwr1),
      .IRWrite_o(irw1), .MemtoReg_o(m2r1), .RegWrite_o(rw1), .RegDst_o(rdst1),
      .ALUSrcA_o(asa1), .PCSrc_o(pcs1), .ALUSrcB_o(asb1), .ALUOp_o(aop1),
      .Retire_o(ret1), .Illegal_o(ill1), .State_o(st1), .InstrCnt_o(cnt1)
   );

   typedef struct packed {
      logic        ret;
      logic        ill;
      logic [3:0]  st;
      logic [15:0] cnt;
   } ev_t;

   ev_t         sb[$];
   ev_t         mon_e;
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] exp_cnt = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Hand-derived control word per state with memory ready.
   function automatic logic [15:0] exp_ctl(input logic [3:0] s);
      case (s)
         4'd0:    return 16'h9404;
         4'd1:    return 16'h000C;
         4'd2:    return 16'h0048;
         4'd3:    return 16'h3000;
         4'd4:    return 16'h0300;
         4'd5:    return 16'h2800;
         4'd6:    return 16'h0042;
         4'd7:    return 16'h0180;
         4'd8:    return 16'h4051;
         4'd9:    return 16'h8020;
         4'd10:   return 16'h0048;
         4'd11:   return 16'h0100;
         default: return 16'h0000;
      endcase
   endfunction

   // Monitor: every retire/illegal pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (ret0 || ill0) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got ret=%0b ill=%0b st=%0d, expected no event (t=%0t)",
                     ret0, ill0, st0, $time);
         end else begin
            mon_e = sb.pop_front();
            check("event", {12'd0, ret0, ill0, st0, cnt0}, {12'd0, mon_e});
         end
      end
   end

   task automatic step0(input logic [3:0] s, input bit do_ctl);
      @(negedge clk);
      #1;
      check("state0", st0, s);
      if (do_ctl) check("ctl0", ctl0, exp_ctl(s));
   endtask

   task automatic step1(input logic [3:0] s);
      @(negedge clk);
      #1;
      check("state1", st1, s);
      check("ctl1", ctl1, exp_ctl(s));
   endtask

   // Starts in an already-checked FETCH cycle; seq lists the following states (top nibble first).
   // kind: 0 none, 1 retire, 2 illegal.
   task automatic run(input logic [5:0] o, input logic n, input logic [23:0] seq, input int len,
                      input int kind);
      ev_t e;
      op   = o;
      noop = n;
      if (kind != 0) begin
         e.ret = (kind == 1);
         e.ill = (kind == 2);
         e.st  = seq[23-4*(len-2) -: 4];
         e.cnt = exp_cnt;
         sb.push_back(e);
         if (kind == 1) exp_cnt++;
      end
      for (int i = 0; i < len; i++) step0(seq[23-4*i -: 4], 1'b1);
      noop = 1'b0;
      check("instr_cnt", cnt0, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; noop = 1'b0; mr = 1'b0; op = 6'd0;
      rst1 = 1'b1; noop1 = 1'b0; mr1 = 1'b0; op1 = 6'd0;

      // Reset held three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_state", st0, 4'd0);
      check("rst_cnt", cnt0, 16'd0);
      check("rst_ctl", ctl0, 16'd0);
      check("rst_pulses", {ret0, ill0}, 2'b00);
      rst = 1'b0;
      step0(4'd0, 1'b0);
      check("fetch_not_ready", ctl0, 16'h1004);
      mr = 1'b1;
      #1;
      check("fetch_ready", ctl0, exp_ctl(4'd0));

      // Main instruction classes at MemReady=1
      run(6'b000000, 1'b0, 24'h167000, 4, 1);  // R
      run(6'b001000, 1'b0, 24'h1AB000, 4, 1);  // addi
      run(6'b101011, 1'b0, 24'h125000, 4, 1);  // sw
      run(6'b000100, 1'b0, 24'h180000, 3, 1);  // beq
      run(6'b000010, 1'b0, 24'h190000, 3, 1);  // j
      run(6'b100011, 1'b0, 24'h123400, 5, 1);  // lw

      // lw with MemReady low for two MEMRD cycles: 7 cycles total
      op = 6'b100011;
      sb.push_back('{ret: 1'b1, ill: 1'b0, st: 4'd4, cnt: exp_cnt});
      exp_cnt++;
      step0(4'd1, 1'b1);
      step0(4'd2, 1'b1);
      mr = 1'b0;
      step0(4'd3, 1'b1);
      step0(4'd3, 1'b1);
      step0(4'd3, 1'b1);
      mr = 1'b1;
      step0(4'd4, 1'b1);
      step0(4'd0, 1'b1);
      check("lw_stall_cnt", cnt0, exp_cnt);

      // Illegal opcode, then the same opcode squashed, then a squashed legal opcode
      run(6'b111111, 1'b0, 24'h100000, 2, 2);
      run(6'b111111, 1'b1, 24'h100000, 2, 0);
      run(6'b000000, 1'b1, 24'h100000, 2, 0);

      // Reset while stalled in MEMRD aborts the load
      op = 6'b100011;
      step0(4'd1, 1'b1);
      step0(4'd2, 1'b1);
      mr = 1'b0;
      step0(4'd3, 1'b1);
      rst = 1'b1;
      step0(4'd0, 1'b0);
      check("abort_cnt", cnt0, 16'd0);
      check("abort_ctl", ctl0, 16'd0);
      check("abort_retire", ret0, 1'b0);
      exp_cnt = '0;
      rst = 1'b0;
      mr  = 1'b1;
      run(6'b000000, 1'b0, 24'h167000, 4, 1);

      // Narrow counter wraps, memory handshake ignored
      rst  = 1'b1;
      rst1 = 1'b0;
      op1  = 6'b000010;
      mr1  = 1'b0;
      for (int i = 0; i < 17; i++) begin
         step1(4'd1);
         step1(4'd9);
         check("j_retire1", ret1, 1'b1);
         step1(4'd0);
         if (i == 15) check("wrap_cnt", cnt1, 4'd0);
      end
      check("final_cnt1", cnt1, 4'd1);
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
